// File: rtl/uart_pkg.sv
// Shared definitions for the loop-back UART: parity modes, FSM state encodings
// and the parity-bit helper used by both the transmitter and the receiver.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity bit that completes the byte for the given mode; 0 when parity is off.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_ODD:  p = ~(^data);
            PAR_EVEN: p = ^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial to byte-parallel receiver: detects the start edge, samples each bit at
// its centre, checks parity and stop bit, and holds good bytes for the consumer.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [1:0] MODE         = PAR_NONE
) (
    input  logic       inclk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       rx_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shreg, sh_d;
    logic          par_q, par_d;
    logic          rxd_q;
    logic [7:0]    data_d;
    logic          rdy_d;
    logic          err_d;
    logic          cnt_done;

    assign cnt_done = (cnt == CNT_LAST);

    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            rxd_q   <= 1'b1;
            rx_data <= 8'h00;
            rx_rdy  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shreg   <= sh_d;
            par_q   <= par_d;
            rxd_q   <= rxd;
            rx_data <= data_d;
            rx_rdy  <= rdy_d;
            rx_err  <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        sh_d    = shreg;
        par_d   = par_q;
        data_d  = rx_data;
        rdy_d   = rx_rdy & ~rx_ack;
        err_d   = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (rxd_q && !rxd) begin
                    state_d = RX_START;
                end
            end
            // Half a bit in: a line back at 1 means the edge was a glitch.
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxd) begin
                        state_d = RX_IDLE;
                    end else begin
                        bit_d   = '0;
                        state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_done) begin
                    cnt_d = '0;
                    sh_d  = {rxd, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d = (MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        bit_d = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RX_PARITY: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    par_d   = rxd;
                    state_d = RX_STOP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rxd && ((MODE == PAR_NONE) || (par_q == parity_bit(shreg, MODE)))) begin
                        data_d = shreg;
                        rdy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_core.sv
// Byte-parallel to serial transmitter: start bit, 8 data bits LSB first,
// optional parity bit, stop bit; every bit lasts CLKS_PER_BIT clocks.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [1:0] MODE         = PAR_NONE
) (
    input  logic       inclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_ack,
    output logic       txd
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shreg, sh_d;
    logic          par_q, par_d;
    logic          ack_d;
    logic          txd_d;
    logic          cnt_done;

    assign cnt_done = (cnt == CNT_LAST);

    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            tx_ack  <= 1'b0;
            txd     <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shreg   <= sh_d;
            par_q   <= par_d;
            tx_ack  <= ack_d;
            txd     <= txd_d;
        end
    end

    // txd is registered and always loaded with the level of the bit being entered,
    // so the line changes exactly on the bit boundary.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        sh_d    = shreg;
        par_d   = par_q;
        ack_d   = 1'b0;
        txd_d   = txd;
        case (state)
            TX_IDLE: begin
                txd_d = 1'b1;
                cnt_d = '0;
                if (tx_req) begin
                    sh_d    = tx_data;
                    par_d   = parity_bit(tx_data, MODE);
                    ack_d   = 1'b1;
                    txd_d   = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = shreg[0];
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_done) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        if (MODE == PAR_NONE) begin
                            txd_d   = 1'b1;
                            state_d = TX_STOP;
                        end else begin
                            txd_d   = par_q;
                            state_d = TX_PARITY;
                        end
                    end else begin
                        bit_d = bit_idx + 1'b1;
                        txd_d = shreg[1];
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            TX_PARITY: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    txd_d   = 1'b1;
                    state_d = TX_STOP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                cnt_d   = '0;
                state_d = TX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_core.sv
// Loop-back UART: the transmitter's line feeds the receiver through a 2-flop
// synchroniser, so received frames trail the transmitted ones by two clocks.
//
// Handshakes: tx_req is a level; the transmitter samples it only in IDLE and
// answers with a one-cycle tx_ack, after which tx_data is no longer needed.
// rx_rdy stays high until rx_ack is seen high on a clock edge while rx_rdy=1;
// it drops on the following cycle. A new good byte overwrites rx_data and
// keeps rx_rdy high.
module uart_core
    import uart_pkg::*;
#(
    parameter string PARITY       = "NONE",
    parameter int    CLKS_PER_BIT = 16
) (
    input  logic       inclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       rx_ack,
    output logic       rx_err,
    output logic       txd
);

    // Unrecognised parity strings fall back to no parity.
    localparam logic [1:0] PAR_MODE = (PARITY == "ODD")  ? PAR_ODD  :
                                      (PARITY == "EVEN") ? PAR_EVEN : PAR_NONE;

    logic [1:0] sync_q;
    logic       rxd_s;

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .MODE         (PAR_MODE)
    ) u_tx (
        .inclk   (inclk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .tx_ack  (tx_ack),
        .txd     (txd)
    );

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], txd};
        end
    end

    assign rxd_s = sync_q[1];

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .MODE         (PAR_MODE)
    ) u_rx (
        .inclk   (inclk),
        .rst     (rst),
        .rxd     (rxd_s),
        .rx_ack  (rx_ack),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .rx_err  (rx_err)
    );

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: three instances (ODD, EVEN, NONE parity) share
// clock, reset and tx_data; expected bytes go through one scoreboard queue.
module tb_uart_core;

    localparam int CPB = 16;

    logic        inclk   = 1'b0;
    logic        rst     = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic [2:0]  tx_req  = 3'b000;
    logic [2:0]  rx_ack  = 3'b000;
    wire  [2:0]  tx_ack;
    wire  [2:0]  rx_rdy;
    wire  [2:0]  rx_err;
    wire  [2:0]  txd;
    wire  [7:0]  rx_data [3];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          err_cnt = 0;
    int          ack_cnt [3];
    logic [2:0]  rdy_q   = 3'b000;
    logic [7:0]  mon_exp;
    logic [7:0]  exp_q [$];

    // ---------------- clock / reset ----------------
    always #5 inclk = ~inclk;
    always @(posedge inclk) cyc <= cyc + 1;

    uart_core #(.PARITY("ODD"), .CLKS_PER_BIT(CPB)) dut_odd (
        .inclk(inclk), .rst(rst), .tx_data(tx_data), .tx_req(tx_req[0]), .tx_ack(tx_ack[0]),
        .rx_data(rx_data[0]), .rx_rdy(rx_rdy[0]), .rx_ack(rx_ack[0]), .rx_err(rx_err[0]), .txd(txd[0]));

    uart_core #(.PARITY("EVEN"), .CLKS_PER_BIT(CPB)) dut_even (
        .inclk(inclk), .rst(rst), .tx_data(tx_data), .tx_req(tx_req[1]), .tx_ack(tx_ack[1]),
        .rx_data(rx_data[1]), .rx_rdy(rx_rdy[1]), .rx_ack(rx_ack[1]), .rx_err(rx_err[1]), .txd(txd[1]));

    uart_core #(.PARITY("NONE"), .CLKS_PER_BIT(CPB)) dut_none (
        .inclk(inclk), .rst(rst), .tx_data(tx_data), .tx_req(tx_req[2]), .tx_ack(tx_ack[2]),
        .rx_data(rx_data[2]), .rx_rdy(rx_rdy[2]), .rx_ack(rx_ack[2]), .rx_err(rx_err[2]), .txd(txd[2]));

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge inclk);
            #1;
        end
    endtask

    task automatic send_byte(input int u, input logic [7:0] b, input bit hold,
                             input bit chk_lat, output int t0);
        int n;
        n = 0;
        tx_data   = b;
        tx_req[u] = 1'b1;
        do begin
            tick(1);
            n++;
        end while (!tx_ack[u] && n < 400);
        check_val("tx_ack_seen", tx_ack[u], 1);
        if (chk_lat) check_val("tx_ack_lat", n, 1);
        if (!hold) tx_req[u] = 1'b0;
        t0 = cyc;
    endtask

    task automatic check_frame(input int u, input logic [7:0] b, input bit has_par,
                               input logic par, input int t0);
        logic [10:0] f;
        int          nb;
        nb = has_par ? 11 : 10;
        f  = has_par ? {1'b1, par, b, 1'b0} : {2'b11, b, 1'b0};
        for (int i = 0; i < nb; i++) begin
            while (cyc < t0 + i * CPB + CPB / 2) tick(1);
            check_val($sformatf("txd_bit%0d", i), txd[u], f[i]);
        end
    endtask

    task automatic wait_rdy(input int u, input int t0, input int nb);
        int n;
        n = 0;
        while (!rx_rdy[u] && n < 600) begin
            tick(1);
            n++;
        end
        check_val("rx_rdy_seen", rx_rdy[u], 1);
        if (rx_rdy[u]) begin
            check_val("rx_lat_lo", (cyc - t0) >= (nb - 1) * CPB + CPB / 2, 1);
            check_val("rx_lat_hi", (cyc - t0) <= nb * CPB + 2, 1);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge inclk) begin
        for (int u = 0; u < 3; u++) begin
            if (rst && rx_rdy[u] && !rdy_q[u]) begin
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    check_val("rx_data", rx_data[u], mon_exp);
                end else begin
                    check_val("rx_spurious", exp_q.size(), 1);
                end
            end
            if (tx_ack[u]) ack_cnt[u]++;
            if (rx_err[u]) err_cnt++;
        end
        rdy_q = rx_rdy;
    end

    // ---------------- stimulus ----------------
    initial begin
        int         t0, ta, tb, a0;
        logic [7:0] seq [4];
        seq = '{8'hFF, 8'h01, 8'h03, 8'h05};

        // Reset with requests pending
        rst    = 1'b0;
        tx_req = 3'b111;
        rx_ack = 3'b110;
        tick(8);
        check_val("rst_txd", txd, 3'b111);
        check_val("rst_tx_ack", tx_ack, 3'b000);
        check_val("rst_rx_rdy", rx_rdy, 3'b000);
        check_val("rst_rx_err", rx_err, 3'b000);
        for (int u = 0; u < 3; u++) check_val("rst_rx_data", rx_data[u], 8'h00);
        tx_req = 3'b000;
        rst    = 1'b1;
        tick(4);

        // ODD parity, 8'hFF: parity bit 1; rx_ack low to test the hold
        exp_q.push_back(8'hFF);
        send_byte(0, 8'hFF, 1'b0, 1'b1, t0);
        check_val("tx_start_low", txd[0], 0);
        tx_data = 8'h00;
        tick(1);
        check_val("tx_ack_pulse", tx_ack[0], 0);
        check_frame(0, 8'hFF, 1'b1, 1'b1, t0);
        wait_rdy(0, t0, 11);
        tick(5);
        check_val("rx_rdy_hold", rx_rdy[0], 1);
        rx_ack[0] = 1'b1;
        tick(1);
        check_val("rx_rdy_clear", rx_rdy[0], 0);

        // Chained traffic with rx_ack held high
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(seq[k]);
            send_byte(0, seq[k], 1'b0, 1'b0, t0);
            wait_rdy(0, t0, 11);
            check_val("rx_chain", rx_data[0], seq[k]);
            tick(1);
            check_val("rx_rdy_1cyc", rx_rdy[0], 0);
        end

        // EVEN parity, 8'h12: two ones, parity bit 0
        exp_q.push_back(8'h12);
        send_byte(1, 8'h12, 1'b0, 1'b1, t0);
        check_frame(1, 8'h12, 1'b1, 1'b0, t0);
        wait_rdy(1, t0, 11);
        check_val("rx_even", rx_data[1], 8'h12);

        // No parity, 8'hA5: 10-bit frame
        exp_q.push_back(8'hA5);
        send_byte(2, 8'hA5, 1'b0, 1'b1, t0);
        check_frame(2, 8'hA5, 1'b0, 1'b0, t0);
        wait_rdy(2, t0, 10);
        check_val("rx_none", rx_data[2], 8'hA5);
        tick(10);

        // Back-to-back frames with tx_req held high
        a0 = ack_cnt[2];
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h5A);
        send_byte(2, 8'h3C, 1'b1, 1'b1, ta);
        send_byte(2, 8'h5A, 1'b1, 1'b0, tb);
        tx_req[2] = 1'b0;
        check_val("b2b_gap", ((tb - ta) >= 161) && ((tb - ta) <= 162), 1);
        wait_rdy(2, tb, 10);
        tick(200);
        check_val("b2b_acks", ack_cnt[2] - a0, 2);

        // Reset in the middle of the data bits
        send_byte(0, 8'h55, 1'b0, 1'b1, t0);
        tick(40);
        rst = 1'b0;
        #1;
        check_val("rst_mid_txd", txd[0], 1);
        check_val("rst_mid_rx_data", rx_data[0], 8'h00);
        tick(3);
        rst = 1'b1;
        tick(400);
        check_val("rst_mid_no_rdy", rx_rdy[0], 0);
        check_val("rst_mid_txd_idle", txd[0], 1);

        // ---------------- final report ----------------
        check_val("rx_err_cnt", err_cnt, 0);
        check_val("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
